nes_joypad_port: RTL and testbench
==================================

Name: nes_joypad_port

Overview:
- CPU-bus responder for the standard-controller registers at $4016/$4017.
- Consumes the cpu_2a03 decode strobes (addr4016w, naddr4016r, naddr4017r) and the CPU write data.
- Holds two 8-bit button shift registers, one per controller. Returns one button bit per CPU read on data bit 0.
- Sits beside memory on the CPU data bus; the top level muxes its data_out onto the bus when data_oe=1.

Parameters:
- OPEN_BUS_HI, 7'b0100000, value driven on data_out[7:1] during reads (matches $40 open-bus pattern).
- SYNC_STAGES, 2, number of synchronizer flops on each button input (min 1).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- nreset  input  1  synchronous active-low reset.
- data_in  input  8  CPU write data; only bit 0 is used.
- addr4016w  input  1  active-high write strobe for $4016, sampled each posedge.
- naddr4016r  input  1  active-low read strobe for $4016 (controller 1).
- naddr4017r  input  1  active-low read strobe for $4017 (controller 2).
- pad1_buttons  input  8  controller 1 buttons, 1=pressed. Bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- pad2_buttons  input  8  controller 2 buttons, same mapping.
- data_out  output  8  read data.
- data_oe  output  1  high while either read strobe is asserted.
- strobe_q  output  1  current latch/strobe register value (debug/visibility).

Behaviour:
- Reset, on posedge with nreset=0:
  - strobe_q=0.
  - sr1=sr2=8'hFF.
  - rd1_prev=rd2_prev=1.
  - Synchronizer flops=0.
  - data_out reflects these values combinationally, so in reset it reads {OPEN_BUS_HI,1} when a strobe is asserted and 8'h00 otherwise.
  - Reset asserted mid-read or mid-shift-sequence discards all progress.
- Synchronizers: pad buttons pass through SYNC_STAGES flops; sync1/sync2 = final stage outputs.
- Strobe write: on a posedge with addr4016w=1, strobe_q <= data_in[0]. Other data_in bits are ignored.
- Reload: on every posedge where the registered strobe_q==1, sr1<=sync1 and sr2<=sync2. This uses strobe_q's value before the edge's update.
  - Consequence: a write of 1 takes effect one cycle after the write.
  - A write of 0 stops reloading from the edge after the write; the last loaded value is retained.
- Shift: each read strobe is edge-detected against its prev flop. A read ends on the posedge where rdN_prev==0 and the strobe input is now 1.
  - At read end, if strobe_q==0: srN <= {1'b1, srN[7:1]} (LSB out, 1 shifted in).
  - After 8 completed reads all further reads return 1 until a reload.
  - If strobe_q==1, reload wins over shift. Reads continuously return the current A button.
- Multi-cycle reads shift exactly once, at the deassertion edge. Back-to-back reads need at least one deasserted cycle between them to count separately.
- Controllers 1 and 2 shift independently; both may end reads on the same edge.
- Read data (combinational from register state):
  - naddr4016r=0: data_out={OPEN_BUS_HI, sr1[0]}.
  - Else naddr4017r=0: data_out={OPEN_BUS_HI, sr2[0]}.
  - Else data_out=8'h00.
  - Both strobes low is illegal; $4016 has priority.
- data_oe = ~naddr4016r | ~naddr4017r, combinational.
- Simultaneous write and read-end on one edge: shift/reload decision uses old strobe_q; the new strobe value applies from the next edge.

Test Plan:
- Reset with pad1_buttons=8'hA5, then eight $4016 reads without strobe write -> each returns 8'h41.
- pad1=8'b1010_0101; write 1 then 0 to $4016; eight 1-cycle reads separated by idle -> bit0 sequence 1,0,1,0,0,1,0,1 (data_out 8'h41/8'h40). Ninth and tenth reads -> 8'h41.
- strobe_q held 1, pad1 bit0 toggling 0/1 across reads -> each read returns the current A, delayed by SYNC_STAGES+1 cycles; sr1 never advances.
- Latch pad1=8'h01, pad2=8'h80; interleave $4016/$4017 reads -> controller 1 gives 1,0,0,..., controller 2 gives 0,...,0,1 (eighth read), independently.
- Read strobe held low 5 cycles -> single shift; next read returns the next bit, not one skipped.
- nreset pulsed low after 3 of 8 reads -> subsequent reads return 1 until a new strobe write 1->0 relatches buttons.

Source files
------------

// File: rtl/nes_joypad_port_if.sv
// CPU-side bus signals for the $4016/$4017 standard-controller port.
// The CPU/decoder side is the master; the joypad responder is the slave.
interface nes_joypad_port_if;
  logic [7:0] data_in;
  logic       addr4016w;
  logic       naddr4016r;
  logic       naddr4017r;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output data_in,
    output addr4016w,
    output naddr4016r,
    output naddr4017r,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  data_in,
    input  addr4016w,
    input  naddr4016r,
    input  naddr4017r,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/nes_joypad_port.sv
// Standard-controller responder at $4016/$4017: latch strobe, two button
// shift registers, and one button bit per CPU read on data bit 0.
module nes_joypad_port #(
  parameter logic [6:0] OPEN_BUS_HI = 7'b0100000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     nreset,
  nes_joypad_port_if.slave         bus,
  input  logic [7:0]               pad1_buttons,
  input  logic [7:0]               pad2_buttons,
  output logic                     strobe_q
);

  logic [7:0] pad1_sync [SYNC_STAGES];
  logic [7:0] pad2_sync [SYNC_STAGES];
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sr1;
  logic [7:0] sr2;
  logic       rd1_prev;
  logic       rd2_prev;
  logic       rd1_end;
  logic       rd2_end;
  logic       unused_data;

  // Only bit 0 of the write data matters for the latch register.
  assign unused_data = ^bus.data_in[7:1];

  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pad1_sync[i] <= '0;
        pad2_sync[i] <= '0;
      end
    end else begin
      pad1_sync[0] <= pad1_buttons;
      pad2_sync[0] <= pad2_buttons;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pad1_sync[i] <= pad1_sync[i-1];
        pad2_sync[i] <= pad2_sync[i-1];
      end
    end
  end

  assign sync1 = pad1_sync[SYNC_STAGES-1];
  assign sync2 = pad2_sync[SYNC_STAGES-1];

  // A read counts when its strobe returns high, so long reads shift once.
  assign rd1_end = ~rd1_prev & bus.naddr4016r;
  assign rd2_end = ~rd2_prev & bus.naddr4017r;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      rd1_prev <= 1'b1;
      rd2_prev <= 1'b1;
    end else begin
      rd1_prev <= bus.naddr4016r;
      rd2_prev <= bus.naddr4017r;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      strobe_q <= 1'b0;
    end else if (bus.addr4016w) begin
      strobe_q <= bus.data_in[0];
    end
  end

  // Reload looks at strobe_q before this edge's write; it wins over a shift.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      sr1 <= 8'hFF;
      sr2 <= 8'hFF;
    end else if (strobe_q) begin
      sr1 <= sync1;
      sr2 <= sync2;
    end else begin
      if (rd1_end) sr1 <= {1'b1, sr1[7:1]};
      if (rd2_end) sr2 <= {1'b1, sr2[7:1]};
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (!bus.naddr4016r)      bus.data_out = {OPEN_BUS_HI, sr1[0]};
    else if (!bus.naddr4017r) bus.data_out = {OPEN_BUS_HI, sr2[0]};
  end

  assign bus.data_oe = ~bus.naddr4016r | ~bus.naddr4017r;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port: directed scenarios plus a random
// phase, all checked against a queue-based model of the controller protocol.
module tb_nes_joypad_port;
  localparam logic [6:0] OPEN_BUS_HI = 7'b0100000;
  localparam int         SYNC_STAGES = 2;

  logic       clock = 1'b0;
  logic       nreset;
  logic [7:0] pad1_buttons;
  logic [7:0] pad2_buttons;
  logic       strobe_q;

  nes_joypad_port_if bus ();

  nes_joypad_port #(.OPEN_BUS_HI(OPEN_BUS_HI), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .bus          (bus.slave),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .strobe_q     (strobe_q)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each controller is a queue of buttons still to be reported
  // (an empty queue reports 1); button inputs reach the latch after a
  // SYNC_STAGES-deep delay queue.
  bit         m_strobe;
  bit         m_bits1[$];
  bit         m_bits2[$];
  bit         m_prev1;
  bit         m_prev2;
  logic [7:0] m_dly1[$];
  logic [7:0] m_dly2[$];

  task automatic model_edge();
    logic [7:0] s1, s2;
    bit e1, e2;
    if (!nreset) begin
      m_strobe = 1'b0;
      m_bits1.delete();
      m_bits2.delete();
      m_prev1 = 1'b1;
      m_prev2 = 1'b1;
      m_dly1.delete();
      m_dly2.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        m_dly1.push_back(8'h00);
        m_dly2.push_back(8'h00);
      end
    end else begin
      s1 = m_dly1[0];
      s2 = m_dly2[0];
      e1 = !m_prev1 && bus.naddr4016r;
      e2 = !m_prev2 && bus.naddr4017r;
      if (m_strobe) begin
        m_bits1.delete();
        m_bits2.delete();
        for (int i = 0; i < 8; i++) begin
          m_bits1.push_back(s1[i]);
          m_bits2.push_back(s2[i]);
        end
      end else begin
        if (e1 && m_bits1.size() > 0) void'(m_bits1.pop_front());
        if (e2 && m_bits2.size() > 0) void'(m_bits2.pop_front());
      end
      if (bus.addr4016w) m_strobe = bus.data_in[0];
      m_prev1 = bus.naddr4016r;
      m_prev2 = bus.naddr4017r;
      void'(m_dly1.pop_front());
      void'(m_dly2.pop_front());
      m_dly1.push_back(pad1_buttons);
      m_dly2.push_back(pad2_buttons);
    end
  endtask

  function automatic logic [7:0] model_data();
    bit b1, b2;
    b1 = (m_bits1.size() > 0) ? m_bits1[0] : 1'b1;
    b2 = (m_bits2.size() > 0) ? m_bits2[0] : 1'b1;
    if (!bus.naddr4016r)      return {OPEN_BUS_HI, b1};
    else if (!bus.naddr4017r) return {OPEN_BUS_HI, b2};
    else                      return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("data_out", bus.data_out, model_data());
    check("data_oe", {7'd0, bus.data_oe}, {7'd0, ~bus.naddr4016r | ~bus.naddr4017r});
    check("strobe_q", {7'd0, strobe_q}, {7'd0, m_strobe});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write4016(input logic [7:0] d);
    bus.addr4016w = 1'b1;
    bus.data_in   = d;
    tick();
    bus.addr4016w = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  task automatic do_read(input int port, input int len, output logic [7:0] first);
    if (port == 1) bus.naddr4016r = 1'b0;
    else           bus.naddr4017r = 1'b0;
    #1;
    first = bus.data_out;
    for (int i = 0; i < len; i++) tick();
    bus.naddr4016r = 1'b1;
    bus.naddr4017r = 1'b1;
    tick();
  endtask

  task automatic latch();
    idle(SYNC_STAGES + 1);
    write4016(8'hFF);
    write4016(8'hFE);
  endtask

  logic [7:0] v;
  logic [7:0] pat;
  int r;

  initial begin
    nreset           = 1'b0;
    bus.data_in      = 8'h00;
    bus.addr4016w    = 1'b0;
    bus.naddr4016r   = 1'b1;
    bus.naddr4017r   = 1'b1;
    pad1_buttons     = 8'hA5;
    pad2_buttons     = 8'h00;
    @(posedge clock); model_edge();
    tick();
    check("reset_idle_data", bus.data_out, 8'h00);
    check("reset_strobe", {7'd0, strobe_q}, 8'h00);
    bus.naddr4016r = 1'b0;
    #1;
    check("reset_read_data", bus.data_out, 8'h41);
    bus.naddr4016r = 1'b1;
    tick();
    nreset = 1'b1;
    idle(2);

    // No latch since reset: every read reports 1.
    for (int i = 0; i < 8; i++) begin
      do_read(1, 1, v);
      check("no_latch_read", v, 8'h41);
    end

    // Latch A5 and read out LSB first, then the ones that follow.
    pat = 8'hA5;
    pad1_buttons = pat;
    latch();
    for (int i = 0; i < 10; i++) begin
      do_read(1, 1, v);
      check("seq_read", v, (i < 8) ? {OPEN_BUS_HI, pat[i]} : 8'h41);
    end

    // Strobe held high: each read follows the current A button.
    write4016(8'h01);
    for (int i = 0; i < 4; i++) begin
      pad1_buttons = {7'b1111111, i[0]};
      idle(SYNC_STAGES + 1);
      do_read(1, 2, v);
      check("strobe_high_read", v, {OPEN_BUS_HI, i[0]});
    end
    write4016(8'h00);

    // Independent controllers, interleaved reads.
    pad1_buttons = 8'h01;
    pad2_buttons = 8'h80;
    latch();
    for (int i = 0; i < 8; i++) begin
      do_read(1, 1, v);
      check("interleave_pad1", v, {OPEN_BUS_HI, (i == 0)});
      do_read(2, 1, v);
      check("interleave_pad2", v, {OPEN_BUS_HI, (i == 7)});
    end

    // A long read shifts once.
    pad1_buttons = 8'h02;
    latch();
    do_read(1, 5, v);
    check("long_read_first", v, 8'h40);
    do_read(1, 1, v);
    check("long_read_next", v, 8'h41);
    do_read(1, 1, v);
    check("long_read_third", v, 8'h40);

    // Reset mid-sequence discards the latch until a new strobe.
    pad1_buttons = 8'h5A;
    latch();
    for (int i = 0; i < 3; i++) do_read(1, 1, v);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_read(1, 1, v);
      check("post_reset_read", v, 8'h41);
    end
    latch();
    do_read(1, 1, v);
    check("relatch_read0", v, 8'h40);
    do_read(1, 1, v);
    check("relatch_read1", v, 8'h41);

    // Random phase, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      nreset = ($urandom_range(0, 199) != 0);
      bus.addr4016w = ($urandom_range(0, 9) == 0);
      bus.data_in = 8'($urandom);
      r = $urandom_range(0, 4);
      bus.naddr4016r = (r != 0);
      bus.naddr4017r = (r != 1);
      if ($urandom_range(0, 4) == 0) pad1_buttons = 8'($urandom);
      if ($urandom_range(0, 4) == 0) pad2_buttons = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
